// File: rtl/fft_frame_feeder_pkg.sv
// Shared definitions for the FFT source-side framer.
//   N_DEF / DW_DEF / GAP_DEF : default frame order, sample width, inter-frame gap
//   FRAME_LEN_DEF            : default frame length in samples (1 << N_DEF)
//   sample_t                 : sample word at the default width
//   rd_state_e               : read-side FSM encoding
package fft_frame_feeder_pkg;

  localparam int N_DEF         = 3;
  localparam int DW_DEF        = 32;
  localparam int GAP_DEF       = 0;
  localparam int FRAME_LEN_DEF = 1 << N_DEF;

  typedef logic [DW_DEF-1:0] sample_t;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_STREAM = 2'd1,
    RD_GAP    = 2'd2
  } rd_state_e;

  function automatic int frame_len(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank sample buffer, 2 x 2^N words of DW bits.
//   clk             : write clock
//   we              : write enable
//   wr_bank/wr_idx  : write address {bank, idx}
//   wr_data         : write word
//   rd_bank/rd_idx  : read address {bank, idx}
//   rd_data         : combinational read word
// No reset: contents are qualified by the bank-full flags in the feeder.
module fft_pingpong_ram #(
  parameter int N  = 3,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic          wr_bank,
  input  logic [N-1:0]  wr_idx,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_bank,
  input  logic [N-1:0]  rd_idx,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2*(1<<N)];

  always_ff @(posedge clk) begin
    if (we) mem[{wr_bank, wr_idx}] <= wr_data;
  end

  assign rd_data = mem[{rd_bank, rd_idx}];

endmodule

// File: rtl/fft_frame_feeder.sv
// Source-side framer for the radix-2 SDF FFT. Buffers upstream samples in a
// ping-pong pair of 2^N-deep banks and emits whole, gap-free frames with a
// start pulse on sample 0 and at least GAP idle cycles between frames.
//   clk, rst_n        : clock, async active-low reset
//   s_data/s_valid/s_ready : upstream sample handshake
//   abort             : discard the partially filled write bank
//   fft_ip            : sample to FFT serial input
//   fft_start         : high on sample 0 of each frame
//   fft_valid         : high on every frame sample
//   frames_sent       : completed-frame counter (wraps)
//
// Read FSM
//   state     | meaning
//   RD_IDLE   | waiting for full[rd_bank]
//   RD_STREAM | presenting bank[rd_bank][rd_idx] to the output register
//   RD_GAP    | enforcing idle spacing after a frame
module fft_frame_feeder
  import fft_frame_feeder_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int DW  = DW_DEF,
  parameter int GAP = GAP_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          abort,
  output logic [DW-1:0] fft_ip,
  output logic          fft_start,
  output logic          fft_valid,
  output logic [15:0]   frames_sent
);

  localparam logic [N-1:0] IDX_LAST = {N{1'b1}};
  localparam logic [N:0]   GAP_LOAD = (GAP > 0) ? (N+1)'(GAP - 1) : '0;

  logic [1:0]    full;
  logic          wr_bank;
  logic          rd_bank;
  logic [N-1:0]  wr_idx;
  logic [N-1:0]  rd_idx, rd_idx_nxt;
  logic [N:0]    gap_cnt, gap_cnt_nxt;
  rd_state_e     state, state_nxt;

  logic          accept;
  logic          wr_en;
  logic          fill_done;
  logic          frame_done;
  logic [1:0]    set_vec;
  logic [1:0]    clr_vec;
  logic          next_ready;
  logic [DW-1:0] rd_data;

  assign s_ready   = rst_n & ~full[wr_bank];
  assign accept    = s_valid & s_ready;
  assign wr_en     = accept & ~abort;
  assign fill_done = wr_en & (wr_idx == IDX_LAST);
  assign set_vec   = fill_done  ? (2'b01 << wr_bank) : 2'b00;
  assign clr_vec   = frame_done ? (2'b01 << rd_bank) : 2'b00;

  // At the end of a frame the other bank may be completing on this very edge;
  // counting that fill keeps frames back-to-back when upstream is streaming.
  assign next_ready = full[~rd_bank] | set_vec[~rd_bank];

  fft_pingpong_ram #(.N(N), .DW(DW)) u_ram (
    .clk     (clk),
    .we      (wr_en),
    .wr_bank (wr_bank),
    .wr_idx  (wr_idx),
    .wr_data (s_data),
    .rd_bank (rd_bank),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  // Write side
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx  <= '0;
      wr_bank <= 1'b0;
    end else if (abort) begin
      wr_idx  <= '0;
    end else if (accept) begin
      wr_idx <= wr_idx + 1'b1;
      if (fill_done) wr_bank <= ~wr_bank;
    end
  end

  // Set and clear never target the same bank: writes only go to a non-full
  // bank, reads only free a full one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) full <= 2'b00;
    else        full <= (full | set_vec) & ~clr_vec;
  end

  // Read FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RD_IDLE;
      rd_idx  <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      rd_idx  <= rd_idx_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  // Read FSM: next state
  always_comb begin
    state_nxt   = state;
    rd_idx_nxt  = rd_idx;
    gap_cnt_nxt = gap_cnt;
    frame_done  = 1'b0;
    case (state)
      RD_IDLE: begin
        if (full[rd_bank]) begin
          state_nxt  = RD_STREAM;
          rd_idx_nxt = '0;
        end
      end
      RD_STREAM: begin
        rd_idx_nxt = rd_idx + 1'b1;
        if (rd_idx == IDX_LAST) begin
          frame_done = 1'b1;
          if (GAP > 0) begin
            state_nxt   = RD_GAP;
            gap_cnt_nxt = GAP_LOAD;
          end else if (!next_ready) begin
            state_nxt = RD_IDLE;
          end
        end
      end
      RD_GAP: begin
        // Terminal count folds in the idle check so the gap is exactly GAP cycles.
        if (gap_cnt == '0) begin
          if (full[rd_bank]) begin
            state_nxt  = RD_STREAM;
            rd_idx_nxt = '0;
          end else begin
            state_nxt = RD_IDLE;
          end
        end else begin
          gap_cnt_nxt = gap_cnt - 1'b1;
        end
      end
      default: state_nxt = RD_IDLE;
    endcase
  end

  // Registered outputs and frame bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fft_ip      <= '0;
      fft_start   <= 1'b0;
      fft_valid   <= 1'b0;
      frames_sent <= '0;
      rd_bank     <= 1'b0;
    end else begin
      if (state == RD_STREAM) begin
        fft_ip    <= rd_data;
        fft_valid <= 1'b1;
        fft_start <= (rd_idx == '0);
      end else begin
        fft_valid <= 1'b0;
        fft_start <= 1'b0;
      end
      if (frame_done) begin
        frames_sent <= frames_sent + 16'd1;
        rd_bank     <= ~rd_bank;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_feeder.sv
module tb_fft_frame_feeder;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int FL = 1 << N;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_data, g_s_data;
  logic          s_valid, g_s_valid;
  logic          s_ready, g_s_ready;
  logic          abort, g_abort;
  logic [DW-1:0] fft_ip, g_fft_ip;
  logic          fft_start, g_fft_start;
  logic          fft_valid, g_fft_valid;
  logic [15:0]   frames_sent, g_frames_sent;

  fft_frame_feeder #(.N(N), .DW(DW), .GAP(0)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .abort(abort), .fft_ip(fft_ip), .fft_start(fft_start), .fft_valid(fft_valid),
    .frames_sent(frames_sent)
  );

  fft_frame_feeder #(.N(N), .DW(DW), .GAP(3)) dut_g (
    .clk(clk), .rst_n(rst_n), .s_data(g_s_data), .s_valid(g_s_valid), .s_ready(g_s_ready),
    .abort(g_abort), .fft_ip(g_fft_ip), .fft_start(g_fft_start), .fft_valid(g_fft_valid),
    .frames_sent(g_frames_sent)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [31:0] out_q[$];
  bit          st_q[$];
  int          cy_q[$];
  logic [31:0] g_out_q[$];
  bit          g_st_q[$];
  int          g_cy_q[$];
  int          stray_start = 0;

  always @(negedge clk) begin
    if (fft_valid) begin
      out_q.push_back(fft_ip); st_q.push_back(fft_start); cy_q.push_back(cyc);
    end else if (fft_start) stray_start++;
    if (g_fft_valid) begin
      g_out_q.push_back(g_fft_ip); g_st_q.push_back(g_fft_start); g_cy_q.push_back(cyc);
    end else if (g_fft_start) stray_start++;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic clear_q();
    out_q.delete(); st_q.delete(); cy_q.delete();
    g_out_q.delete(); g_st_q.delete(); g_cy_q.delete();
  endtask

  task automatic drive(input bit sel, input bit v, input int d);
    if (sel) begin g_s_valid = v; g_s_data = d; end
    else     begin s_valid = v;   s_data = d;   end
  endtask

  task automatic send(input bit sel, input int n, input int base, input bit throttle,
                      output int last_acc, output int stall_at);
    int  i = 0;
    int  guard = 0;
    bit  phase = 0;
    bit  rdy;
    last_acc = -1;
    stall_at = -1;
    while (i < n && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (throttle && phase) begin
        drive(sel, 1'b0, 0);
      end else begin
        drive(sel, 1'b1, base + i);
        rdy = sel ? g_s_ready : s_ready;
        if (rdy) begin
          i++;
          last_acc = cyc + 1;
        end else if (stall_at < 0) begin
          stall_at = i;
        end
      end
      phase = ~phase;
    end
    @(negedge clk);
    drive(sel, 1'b0, 0);
  endtask

  task automatic wait_out(input bit sel, input int n, input int budget);
    int w = 0;
    while (((sel ? g_out_q.size() : out_q.size()) < n) && w < budget) begin
      @(negedge clk);
      w++;
    end
    repeat (12) @(negedge clk);
  endtask

  // Checks the main-instance capture against base..base+n-1 framed every FL samples.
  task automatic chk_stream(input string name, input int n, input int base);
    int bad_d = 0, bad_s = 0, bad_c = 0;
    chk({name, "_count"}, out_q.size(), n);
    for (int k = 0; k < out_q.size() && k < n; k++) begin
      if (out_q[k] != 32'(base + k)) bad_d++;
      if (st_q[k] != ((k % FL) == 0)) bad_s++;
      if (cy_q[k] != cy_q[0] + k) bad_c++;
    end
    chk({name, "_data_errs"}, bad_d, 0);
    chk({name, "_start_errs"}, bad_s, 0);
    chk({name, "_gapfree_errs"}, bad_c, 0);
  endtask

  typedef struct {
    string name;
    int    nsamp;
    bit    throttle;
    int    base;
    int    frames;
    int    stall_at;
    bit    chk_lat;
  } vec_t;

  vec_t vecs[3];
  int   exp_fs = 0;

  initial begin
    int last_acc, stall_at;

    vecs[0] = '{"single",    8, 1'b0, 1, 1, -1, 1'b1};
    vecs[1] = '{"throttled", 8, 1'b1, 1, 1, -1, 1'b0};
    vecs[2] = '{"backpress", 24, 1'b0, 1, 3, 16, 1'b0};

    rst_n = 1'b0;
    s_valid = 0; s_data = 0; abort = 0;
    g_s_valid = 0; g_s_data = 0; g_abort = 0;
    repeat (2) @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_fft_valid", fft_valid, 0);
    chk("rst_fft_start", fft_start, 0);
    chk("rst_fft_ip", fft_ip, 0);
    chk("rst_frames", frames_sent, 0);
    chk("rst_g_valid", g_fft_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_s_ready", s_ready, 1);
    chk("post_rst_g_s_ready", g_s_ready, 1);

    foreach (vecs[v]) begin
      clear_q();
      send(1'b0, vecs[v].nsamp, vecs[v].base, vecs[v].throttle, last_acc, stall_at);
      wait_out(1'b0, vecs[v].nsamp, 200);
      chk_stream(vecs[v].name, vecs[v].nsamp, vecs[v].base);
      exp_fs += vecs[v].frames;
      chk({vecs[v].name, "_frames_sent"}, frames_sent, exp_fs);
      chk({vecs[v].name, "_stall_at"}, stall_at, vecs[v].stall_at);
      if (vecs[v].chk_lat) begin
        if (cy_q.size() > 0) chk({vecs[v].name, "_start_latency"}, cy_q[0] - last_acc, 2);
        else chk({vecs[v].name, "_start_latency"}, -1, 2);
      end
    end

    // GAP=3 instance, two full banks
    clear_q();
    send(1'b1, 16, 500, 1'b0, last_acc, stall_at);
    wait_out(1'b1, 16, 200);
    chk("gap_count", g_out_q.size(), 16);
    if (g_out_q.size() >= 16) begin
      int bad = 0;
      for (int k = 0; k < 16; k++) begin
        if (g_out_q[k] != 32'(500 + k)) bad++;
        if (g_st_q[k] != ((k % FL) == 0)) bad++;
      end
      chk("gap_data_start_errs", bad, 0);
      chk("gap_frame1_len", g_cy_q[7] - g_cy_q[0], 7);
      chk("gap_idle_cycles", g_cy_q[8] - g_cy_q[7] - 1, 3);
      chk("gap_frame2_len", g_cy_q[15] - g_cy_q[8], 7);
    end
    chk("gap_frames_sent", g_frames_sent, 2);

    // abort after 5 accepts; an accept coinciding with abort is dropped
    clear_q();
    send(1'b0, 5, 50, 1'b0, last_acc, stall_at);
    @(negedge clk);
    abort = 1'b1; s_valid = 1'b1; s_data = 99;
    @(negedge clk);
    abort = 1'b0; s_valid = 1'b0;
    send(1'b0, 8, 100, 1'b0, last_acc, stall_at);
    wait_out(1'b0, 8, 200);
    chk_stream("abort", 8, 100);
    exp_fs += 1;
    chk("abort_frames_sent", frames_sent, exp_fs);

    // reset mid-stream
    clear_q();
    send(1'b0, 8, 200, 1'b0, last_acc, stall_at);
    begin
      int w = 0;
      while (out_q.size() < 4 && w < 100) begin @(negedge clk); w++; end
    end
    chk("midrst_reached_stream", fft_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_fft_valid", fft_valid, 0);
    chk("midrst_fft_start", fft_start, 0);
    chk("midrst_frames", frames_sent, 0);
    chk("midrst_s_ready", s_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_fs = 0;
    @(negedge clk);
    chk("midrst_release_s_ready", s_ready, 1);
    clear_q();
    send(1'b0, 8, 300, 1'b0, last_acc, stall_at);
    wait_out(1'b0, 8, 200);
    chk_stream("after_rst", 8, 300);
    exp_fs += 1;
    chk("after_rst_frames_sent", frames_sent, exp_fs);

    chk("stray_start", stray_start, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fft_frame_feeder.md
Name: fft_frame_feeder

Overview:
Source-side framer for the radix-2 SDF FFT pipeline. It accepts real samples from upstream over a valid/ready handshake and buffers them in a ping-pong pair of 2^N-deep banks. It then drives the FFT's serial input as contiguous frames: a one-cycle start pulse with the first sample, followed by back-to-back samples. It guarantees the FFT never sees a partial or gapped frame, and it enforces a minimum idle spacing between frames.

Parameters:
N, 3, log2 of frame length. A frame is 2^N samples; must match the FFT's N.
DW, 32, sample word width in bits (opaque payload; same encoding as the shared sample type).
GAP, 0, minimum idle cycles between the last sample of one frame and the start of the next (0..2^N).

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
s_data  in  DW  upstream sample
s_valid  in  1  upstream sample valid
s_ready  out  1  feeder can accept s_data this cycle
abort  in  1  synchronous discard of the partially filled write bank
fft_ip  out  DW  sample to FFT serial input
fft_start  out  1  high for exactly the cycle carrying sample 0 of a frame
fft_valid  out  1  high on every cycle carrying a frame sample
frames_sent  out  16  count of completed frames, wraps modulo 2^16

Behaviour:
- Reset (rst_n low, asynchronous):
  - fft_ip=0, fft_start=0, fft_valid=0, frames_sent=0.
  - Both bank-full flags clear; wr_bank=0, rd_bank=0, wr_idx=0.
  - Read FSM=IDLE; s_ready=0 while rst_n is low.
- Write side:
  - Accept occurs when s_valid & s_ready. The sample is stored at bank[wr_bank][wr_idx] and wr_idx increments.
  - On the accept with wr_idx=2^N-1: set full[wr_bank], toggle wr_bank, wr_idx wraps to 0.
  - s_ready = rst_n & ~full[wr_bank]. It depends only on registers and is never dependent on s_valid.
  - abort resets wr_idx to 0 and drops the partial frame. Full banks and any frame in flight are unaffected. If abort and an accept coincide, abort wins and the sample is dropped.
- Read FSM (outputs registered):
  - IDLE: if full[rd_bank], go to STREAM with rd_idx=0.
  - STREAM: each cycle present bank[rd_bank][rd_idx] on fft_ip with fft_valid=1; fft_start=1 only when rd_idx=0.
    - On rd_idx=2^N-1: clear full[rd_bank], toggle rd_bank, increment frames_sent.
    - Then go to GAP if GAP>0; otherwise go to STREAM again (rd_idx=0) if the next bank is full, else IDLE.
  - GAP: hold for GAP cycles with fft_valid=0, then return to IDLE evaluation, so the next frame can start on the following cycle.
- Latency: if the last sample of a frame is accepted at edge t with the read side in IDLE, fft_start=1 appears after edge t+2 (one cycle to detect full, one cycle for the output register).
- Back-to-back operation: with GAP=0 and both banks full, the next frame's fft_start directly follows the previous frame's last sample with no bubble.
- Simultaneous events: the write side filling one bank in the same cycle the read side frees the other bank is legal. s_ready rises on the cycle after the full flag is cleared.
- Frame ordering is strictly bank 0, 1, 0, 1, ...
- Reset mid-stream: all outputs drop immediately and buffered data is discarded.

Decomposition:
- Shared package: sample typedef (DW-wide), N and GAP defaults, frame-length constant 1<<N.
- One sub-module: fft_pingpong_ram, a 2-bank by 2^N by DW register array with one write port and one read port addressed by {bank, idx}.
- Both FSMs and the counters live in fft_frame_feeder.

Test Plan:
- Single frame (N=3, GAP=0): s_valid continuous with samples 1..8 -> s_ready high for 8 accepts. fft_start=1 exactly once, 2 cycles after the 8th accept, carrying 1. fft_valid high for 8 cycles with 1..8 in order. frames_sent=1.
- Throttled upstream: s_valid toggles every other cycle for 8 samples -> one gap-free output burst after the 8th accept, same ordering.
- Backpressure: 24 samples offered continuously with GAP=0 -> s_ready drops after 16 accepts until frame 1 finishes. Output is 24 contiguous valid cycles with fft_start at sample offsets 0, 8, 16. frames_sent=3.
- GAP=3 with two full banks -> exactly 3 cycles of fft_valid=0 between frame 1's last sample and frame 2's fft_start.
- abort after 5 accepts, then samples 100..107 -> the emitted frame is 100..107; none of the first 5 samples are ever emitted.
- rst_n pulsed low mid-STREAM (sample 4 of 8) -> fft_valid, fft_start and frames_sent are 0 immediately. After release, s_ready=1 and a new 8-sample frame streams correctly.
